// File: rtl/adc_capture_pkg.sv
// Shared types and constants for the ADC pulse-capture stage.
//   state_e     : capture controller states
//   sample_t    : one signed channel sample
//   pair_t      : packed {b, a} sample pair as stored and streamed
//   TRIG_CNT_W  : width of the saturating capture counter
package adc_capture_pkg;

  localparam int unsigned CAP_DATA_W = 12;
  localparam int unsigned TRIG_CNT_W = 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FILL,
    S_WAIT_TRIG,
    S_POST,
    S_DRAIN
  } state_e;

  typedef logic signed [CAP_DATA_W-1:0] sample_t;

  typedef struct packed {
    sample_t b;
    sample_t a;
  } pair_t;

endpackage

// File: rtl/adc_pulse_capture_ram.sv
// Simple dual-port RAM for the capture ring buffer.
//   clk   : clock
//   we    : write enable, waddr/wdata written on the rising edge
//   re    : read enable; rdata updates one cycle after re, holds otherwise
//   raddr : read address
//   rdata : registered read data
module capture_ram
  import adc_capture_pkg::*;
#(
  parameter int unsigned ADDR_W = 7,
  parameter int unsigned WIDTH  = 2 * CAP_DATA_W
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  rdata
);

  logic [WIDTH-1:0] mem [2**ADDR_W];
  logic [WIDTH-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    if (re) begin
      rdata_q <= mem[raddr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/adc_pulse_capture.sv
// Pulse-capture stage: keeps a rolling pre-trigger history of channel A/B
// sample pairs, freezes PRE_SAMPLES+POST_SAMPLES pairs around an upward
// threshold crossing on channel A, then drains them over valid/ready.
//   clk, rst        : sample clock, async active-high reset
//   sample_valid    : sample_a/sample_b present this cycle
//   threshold       : signed trigger level, latched on arm
//   arm, auto_rearm : start a capture / restart after each drain
//   m_data/m_valid/m_ready/m_last : output stream, {b, a} per beat
//   busy            : controller not idle
//   trig_count      : saturating count of captured windows
module adc_pulse_capture
  import adc_capture_pkg::*;
#(
  parameter int unsigned DATA_W       = CAP_DATA_W,
  parameter int unsigned ADDR_W       = 7,
  parameter int unsigned PRE_SAMPLES  = 16,
  parameter int unsigned POST_SAMPLES = 48
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sample_valid,
  input  logic [DATA_W-1:0]     sample_a,
  input  logic [DATA_W-1:0]     sample_b,
  input  logic [DATA_W-1:0]     threshold,
  input  logic                  arm,
  input  logic                  auto_rearm,
  output logic [2*DATA_W-1:0]   m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  m_last,
  output logic                  busy,
  output logic [TRIG_CNT_W-1:0] trig_count
);

  localparam int unsigned CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0]  PRE_C  = CNT_W'(PRE_SAMPLES);
  localparam logic [CNT_W-1:0]  POST_C = CNT_W'(POST_SAMPLES);
  localparam logic [CNT_W-1:0]  WIN_C  = CNT_W'(PRE_SAMPLES + POST_SAMPLES);
  localparam logic [ADDR_W-1:0] PRE_A  = ADDR_W'(PRE_SAMPLES);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);
  // With no pre-trigger history there is nothing to fill first.
  localparam state_e ARM_STATE = (PRE_SAMPLES == 0) ? S_WAIT_TRIG : S_FILL;

  state_e                     state_q, state_d;
  logic [ADDR_W-1:0]          wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0]          rd_ptr_q, rd_ptr_d;
  logic signed [DATA_W-1:0]   thr_q, thr_d;
  logic signed [DATA_W-1:0]   prev_a_q, prev_a_d;
  logic                       prev_vld_q, prev_vld_d;
  logic [CNT_W-1:0]           cnt_q, cnt_d;
  logic [CNT_W-1:0]           rd_left_q, rd_left_d;
  logic [TRIG_CNT_W-1:0]      trig_cnt_q, trig_cnt_d;
  logic                       rv_q, rv_d;
  logic                       rv_last_q, rv_last_d;
  logic                       m_valid_q, m_valid_d;
  logic                       m_last_q, m_last_d;
  logic [2*DATA_W-1:0]        m_data_q, m_data_d;

  logic                       ram_we;
  logic                       ram_re;
  logic [2*DATA_W-1:0]        ram_rdata;
  logic                       adv;
  logic                       trig;

  capture_ram #(
    .ADDR_W (ADDR_W),
    .WIDTH  (2 * DATA_W)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (wr_ptr_q),
    .wdata ({sample_b, sample_a}),
    .re    (ram_re),
    .raddr (rd_ptr_q),
    .rdata (ram_rdata)
  );

  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    thr_d      = thr_q;
    prev_a_d   = prev_a_q;
    prev_vld_d = prev_vld_q;
    cnt_d      = cnt_q;
    rd_left_d  = rd_left_q;
    trig_cnt_d = trig_cnt_q;
    rv_d       = rv_q;
    rv_last_d  = rv_last_q;
    m_valid_d  = m_valid_q;
    m_last_d   = m_last_q;
    m_data_d   = m_data_q;
    ram_we     = 1'b0;

    trig = prev_vld_q && (prev_a_q < thr_q) && ($signed(sample_a) >= thr_q);

    // Two-stage read pipeline (RAM output register, then output register).
    // A read is issued only when its result has somewhere to go, so the
    // RAM output simply holds while the stream is stalled.
    adv    = !m_valid_q || m_ready;
    ram_re = (state_q == S_DRAIN) && (rd_left_q != '0) && (!rv_q || adv);

    if (adv) begin
      m_valid_d = rv_q;
      m_last_d  = rv_q && rv_last_q;
      if (rv_q) begin
        m_data_d = ram_rdata;
      end
    end

    if (ram_re) begin
      rv_d      = 1'b1;
      rv_last_d = (rd_left_q == CNT_ONE);
      rd_ptr_d  = rd_ptr_q + ADDR_ONE;
      rd_left_d = rd_left_q - CNT_ONE;
    end else if (adv) begin
      rv_d = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        if (arm) begin
          thr_d      = threshold;
          cnt_d      = '0;
          prev_vld_d = 1'b0;
          state_d    = ARM_STATE;
        end
      end

      S_FILL: begin
        if (sample_valid) begin
          ram_we     = 1'b1;
          wr_ptr_d   = wr_ptr_q + ADDR_ONE;
          prev_a_d   = sample_a;
          prev_vld_d = 1'b1;
          cnt_d      = cnt_q + CNT_ONE;
          if (cnt_q + CNT_ONE == PRE_C) begin
            state_d = S_WAIT_TRIG;
          end
        end
      end

      S_WAIT_TRIG: begin
        if (sample_valid) begin
          ram_we     = 1'b1;
          wr_ptr_d   = wr_ptr_q + ADDR_ONE;
          prev_a_d   = sample_a;
          prev_vld_d = 1'b1;
          if (trig) begin
            rd_ptr_d  = wr_ptr_q - PRE_A;
            rd_left_d = WIN_C;
            cnt_d     = CNT_ONE;
            if (trig_cnt_q != '1) begin
              trig_cnt_d = trig_cnt_q + TRIG_CNT_W'(1);
            end
            state_d = (POST_SAMPLES == 1) ? S_DRAIN : S_POST;
          end
        end
      end

      S_POST: begin
        if (sample_valid) begin
          ram_we     = 1'b1;
          wr_ptr_d   = wr_ptr_q + ADDR_ONE;
          prev_a_d   = sample_a;
          prev_vld_d = 1'b1;
          cnt_d      = cnt_q + CNT_ONE;
          if (cnt_q + CNT_ONE == POST_C) begin
            state_d = S_DRAIN;
          end
        end
      end

      S_DRAIN: begin
        if (m_valid_q && m_ready && m_last_q) begin
          if (auto_rearm) begin
            cnt_d      = '0;
            prev_vld_d = 1'b0;
            state_d    = ARM_STATE;
          end else begin
            state_d = S_IDLE;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      thr_q      <= '0;
      prev_a_q   <= '0;
      prev_vld_q <= 1'b0;
      cnt_q      <= '0;
      rd_left_q  <= '0;
      trig_cnt_q <= '0;
      rv_q       <= 1'b0;
      rv_last_q  <= 1'b0;
      m_valid_q  <= 1'b0;
      m_last_q   <= 1'b0;
      m_data_q   <= '0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      thr_q      <= thr_d;
      prev_a_q   <= prev_a_d;
      prev_vld_q <= prev_vld_d;
      cnt_q      <= cnt_d;
      rd_left_q  <= rd_left_d;
      trig_cnt_q <= trig_cnt_d;
      rv_q       <= rv_d;
      rv_last_q  <= rv_last_d;
      m_valid_q  <= m_valid_d;
      m_last_q   <= m_last_d;
      m_data_q   <= m_data_d;
    end
  end

  assign m_data     = m_data_q;
  assign m_valid    = m_valid_q;
  assign m_last     = m_last_q;
  assign busy       = (state_q != S_IDLE);
  assign trig_count = trig_cnt_q;

endmodule

// File: tb/tb_adc_pulse_capture.sv
// Directed bench for adc_pulse_capture: ramp captures, backpressure,
// sample gaps, flat-level no-false-trigger, ring wrap and mid-drain reset.
module tb_adc_pulse_capture;
  import adc_capture_pkg::*;

  localparam int DW = 12;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            sample_valid = 1'b0;
  logic [DW-1:0]   sample_a = '0;
  logic [DW-1:0]   sample_b = '0;
  logic [DW-1:0]   threshold = '0;
  logic            arm = 1'b0;
  logic            auto_rearm = 1'b0;
  logic            m_ready = 1'b1;
  logic [2*DW-1:0] m_data;
  logic            m_valid;
  logic            m_last;
  logic            busy;
  logic [15:0]     trig_count;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  adc_pulse_capture #(
    .DATA_W       (DW),
    .ADDR_W       (7),
    .PRE_SAMPLES  (16),
    .POST_SAMPLES (48)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .sample_valid (sample_valid),
    .sample_a     (sample_a),
    .sample_b     (sample_b),
    .threshold    (threshold),
    .arm          (arm),
    .auto_rearm   (auto_rearm),
    .m_data       (m_data),
    .m_valid      (m_valid),
    .m_ready      (m_ready),
    .m_last       (m_last),
    .busy         (busy),
    .trig_count   (trig_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: only this process writes these; the stimulus reads snapshots.
  logic [2*DW-1:0] got_d[$];
  bit              got_l[$];
  int              got_c[$];
  int              cyc = 0;
  int              n_last = 0;
  int              n_vcyc = 0;
  int              drain_cyc = 0;
  int              v_rise_cyc = 0;
  logic [6:0]      drain_rd_ptr = '0;
  bit              was_drain = 0;
  bit              prev_v = 0;
  bit              stall_q = 0;
  logic [2*DW-1:0] stall_d = '0;
  logic            stall_l = 1'b0;

  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      stall_q   = 0;
      was_drain = 0;
      prev_v    = 0;
    end else begin
      if (stall_q) begin
        chk("hold_valid", 32'(m_valid), 32'd1);
        chk("hold_data", 32'(m_data), 32'(stall_d));
        chk("hold_last", 32'(m_last), 32'(stall_l));
      end
      if (dut.state_q == S_DRAIN && !was_drain) begin
        drain_cyc    = cyc;
        drain_rd_ptr = dut.rd_ptr_q;
      end
      was_drain = (dut.state_q == S_DRAIN);
      if (m_valid && !prev_v) v_rise_cyc = cyc;
      prev_v = m_valid;
      if (m_valid) n_vcyc++;
      if (m_valid && m_ready) begin
        got_d.push_back(m_data);
        got_l.push_back(m_last);
        got_c.push_back(cyc);
        if (m_last) n_last++;
      end
      stall_q = m_valid && !m_ready;
      stall_d = m_data;
      stall_l = m_last;
    end
  end

  function automatic int gen(input int mode, input int start, input int idx);
    if (mode == 0) return start + idx;
    if (idx < 100) return 200;
    if (idx == 100) return 99;
    return idx - 1;
  endfunction

  function automatic int exp_a(input int mode, input int thr, input int i);
    if (mode == 0) return thr - 16 + i;
    if (i < 15) return 200;
    if (i == 15) return 99;
    return 100 + (i - 16);
  endfunction

  // Arms with a junk (valid) sample on the arm cycle, then streams samples
  // until the m_last handshake (or abort_n handshakes) or a cycle budget.
  task automatic capture(input int mode, input int start, input int thr,
                         input bit gaps, input bit rnd, input bit rearm,
                         input int abort_n, output int base);
    int idx;
    int nl0;
    int nv0;
    int v;
    int vb;
    bit ok;
    idx  = 0;
    base = got_d.size();
    nl0  = n_last;
    nv0  = n_vcyc;
    ok   = 0;
    auto_rearm   = rearm;
    arm          = 1'b1;
    threshold    = thr[DW-1:0];
    sample_valid = 1'b1;
    sample_a     = 12'd2000;
    sample_b     = 12'd0;
    m_ready      = 1'b1;
    step();
    chk("busy_rise", 32'(busy), 32'd1);
    arm       = 1'b0;
    threshold = 12'h7ff;
    for (int c = 0; c < 4000; c++) begin
      if (gaps && (c % 2 == 1)) begin
        sample_valid = 1'b0;
        sample_a     = 12'h800;
        sample_b     = 12'h800;
      end else begin
        if (mode == 1 && idx == 100) begin
          chk("flat_state", 32'(dut.state_q), 32'(S_WAIT_TRIG));
          chk("flat_no_valid", 32'(n_vcyc), 32'(nv0));
        end
        v  = gen(mode, start, idx);
        vb = v + 1000;
        sample_valid = 1'b1;
        sample_a     = v[DW-1:0];
        sample_b     = vb[DW-1:0];
        idx++;
      end
      m_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      step();
      if (abort_n > 0) begin
        if (got_d.size() - base >= abort_n) begin ok = 1; break; end
      end else if (n_last != nl0) begin
        ok = 1;
        break;
      end
    end
    chk("capture_timeout", 32'(ok), 32'd1);
    sample_valid = 1'b0;
    m_ready      = 1'b1;
  endtask

  task automatic check_window(input string tag, input int mode, input int thr, input int base);
    int ea;
    int eb;
    logic [2*DW-1:0] e;
    chk({tag, "_count"}, 32'(got_d.size() - base), 32'd64);
    for (int i = 0; i < 64; i++) begin
      if (base + i < got_d.size()) begin
        ea = exp_a(mode, thr, i);
        eb = ea + 1000;
        e  = {eb[DW-1:0], ea[DW-1:0]};
        chk($sformatf("%s_d%0d", tag, i), 32'(got_d[base + i]), 32'(e));
        chk($sformatf("%s_l%0d", tag, i), 32'(got_l[base + i]), 32'(i == 63));
      end
    end
  endtask

  initial begin
    int b;
    int nl;
    repeat (3) step();
    rst = 1'b0;
    step();

    chk("rst_m_valid", 32'(m_valid), 32'd0);
    chk("rst_m_last", 32'(m_last), 32'd0);
    chk("rst_m_data", 32'(m_data), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_trig_count", 32'(trig_count), 32'd0);
    chk("rst_state", 32'(dut.state_q), 32'(S_IDLE));
    chk("rst_wr_ptr", 32'(dut.wr_ptr_q), 32'd0);

    // Basic ramp capture.
    capture(0, -50, 100, 0, 0, 0, 0, b);
    check_window("basic", 0, 100, b);
    chk("basic_trig", 32'(trig_count), 32'd1);
    chk("basic_busy_fall", 32'(busy), 32'd0);
    if (got_d.size() - b == 64)
      chk("basic_burst", 32'(got_c[b + 63] - got_c[b]), 32'd63);
    chk("basic_latency", 32'(v_rise_cyc - drain_cyc), 32'd2);

    // Random backpressure.
    capture(0, -50, 100, 0, 1, 0, 0, b);
    check_window("bp", 0, 100, b);
    chk("bp_trig", 32'(trig_count), 32'd2);
    chk("bp_latency", 32'(v_rise_cyc - drain_cyc), 32'd2);

    // Invalid cycle every other cycle.
    capture(0, -50, 100, 1, 0, 0, 0, b);
    check_window("gap", 0, 100, b);
    chk("gap_trig", 32'(trig_count), 32'd3);

    // Flat level above threshold, then 99 -> 100; auto re-arm afterwards.
    capture(1, 0, 100, 0, 0, 1, 0, b);
    check_window("flat", 1, 100, b);
    chk("flat_trig", 32'(trig_count), 32'd4);
    chk("rearm_state", 32'(dut.state_q), 32'(S_FILL));
    chk("rearm_busy", 32'(busy), 32'd1);

    auto_rearm = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    chk("rst2_trig_count", 32'(trig_count), 32'd0);

    // Trigger at write index 264 -> trig_addr 8, window starts at 120.
    capture(0, -164, 100, 0, 0, 0, 0, b);
    check_window("wrap", 0, 100, b);
    chk("wrap_rd_ptr", 32'(drain_rd_ptr), 32'd120);
    chk("wrap_trig", 32'(trig_count), 32'd1);

    // Reset after 10 drained pairs.
    nl = n_last;
    capture(0, -50, 100, 0, 0, 0, 10, b);
    chk("abort_busy_pre", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    chk("abort_m_valid", 32'(m_valid), 32'd0);
    chk("abort_m_last", 32'(m_last), 32'd0);
    chk("abort_m_data", 32'(m_data), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_trig_count", 32'(trig_count), 32'd0);
    chk("abort_state", 32'(dut.state_q), 32'(S_IDLE));
    chk("abort_no_last", 32'(n_last), 32'(nl));
    step();
    rst = 1'b0;
    repeat (3) step();
    chk("post_abort_valid", 32'(m_valid), 32'd0);
    chk("post_abort_state", 32'(dut.state_q), 32'(S_IDLE));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
